// File: rtl/countdown_timer.sv
// Loadable down-counter with a one-cycle terminal-count pulse.
// Define COUNTDOWN_AUTO_RELOAD_EN for periodic mode (reload from period after reaching zero).
module countdown_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             zero,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] out_reg;
  logic             done_reg;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] period_reg;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      out_reg   <= '0;
      done_reg  <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      period_reg <= '0;
`endif
    end else begin
      done_reg <= 1'b0;
      if (load) begin
        out_reg   <= load_value;
        state_reg <= (load_value != '0) ? RUN : IDLE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        period_reg <= load_value;
`endif
      end else if (state_reg == RUN && enable) begin
        if (out_reg > WIDTH'(1)) begin
          out_reg <= out_reg - WIDTH'(1);
        end else if (out_reg == WIDTH'(1)) begin
          out_reg  <= '0;
          done_reg <= 1'b1;
`ifndef COUNTDOWN_AUTO_RELOAD_EN
          state_reg <= IDLE;
`endif
        end else begin
          // Zero while running: only reachable in periodic mode, where it restarts.
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          out_reg <= period_reg;
`else
          state_reg <= IDLE;
`endif
        end
      end
    end
  end

  assign out  = out_reg;
  assign busy = (state_reg == RUN);
  assign zero = (out_reg == '0);
  assign done = done_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: stimulus pushes the expected post-edge outputs,
// a monitor pops and compares one entry per clock edge.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = 8'h00;
  logic [7:0] out;
  logic       busy;
  logic       zero;
  logic       done;

  typedef struct {
    string      name;
    logic [7:0] out;
    logic       busy;
    logic       zero;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  countdown_timer #(.WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .load(load),
    .load_value(load_value),
    .out(out),
    .busy(busy),
    .zero(zero),
    .done(done)
  );

  always #5 clk = ~clk;

  // Monitor: every edge presents a new output word; compare it against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      if (out !== e.out || busy !== e.busy || zero !== e.zero || done !== e.done) begin
        miscompares++;
        $display("FAIL %s: got out=%0d busy=%b zero=%b done=%b, expected out=%0d busy=%b zero=%b done=%b",
                 e.name, out, busy, zero, done, e.out, e.busy, e.zero, e.done);
      end else begin
        $display("ok   %s: out=%0d busy=%b zero=%b done=%b", e.name, out, busy, zero, done);
      end
    end
  end

  // Drive one cycle of inputs and record what the outputs must read after the edge.
  task automatic step(input string name, input logic r, input logic ld, input logic [7:0] lv,
                      input logic en, input logic [7:0] eo, input logic eb, input logic ed);
    exp_t e;
    reset = r;
    load = ld;
    load_value = lv;
    enable = en;
    e.name = name;
    e.out = eo;
    e.busy = eb;
    e.zero = (eo == 8'd0);
    e.done = ed;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #2;
    step("reset0", 1, 1, 8'h55, 0, 0, 0, 0);
    step("reset1", 1, 1, 8'h55, 0, 0, 0, 0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    step("ar_load2", 0, 1, 8'd2, 1, 2, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step("ar_1", 0, 0, 0, 1, 1, 1, 0);
      step("ar_0", 0, 0, 0, 1, 0, 1, 1);
      step("ar_2", 0, 0, 0, 1, 2, 1, 0);
    end
    step("ar_hold", 0, 0, 0, 0, 2, 1, 0);
    step("ar_1b", 0, 0, 0, 1, 1, 1, 0);
    step("ar_0b", 0, 0, 0, 1, 0, 1, 1);
    step("ar_hold0", 0, 0, 0, 0, 0, 1, 0);
    step("ar_reld", 0, 0, 0, 1, 2, 1, 0);
    step("ar_load0", 0, 1, 8'd0, 1, 0, 0, 0);
    step("ar_idle", 0, 0, 0, 1, 0, 0, 0);
`else
    // One-shot from 5.
    step("os_load5", 0, 1, 8'd5, 1, 5, 1, 0);
    step("os_4", 0, 0, 0, 1, 4, 1, 0);
    step("os_3", 0, 0, 0, 1, 3, 1, 0);
    step("os_2", 0, 0, 0, 1, 2, 1, 0);
    step("os_1", 0, 0, 0, 1, 1, 1, 0);
    step("os_0done", 0, 0, 0, 1, 0, 0, 1);
    step("os_idle_a", 0, 0, 0, 1, 0, 0, 0);
    step("os_idle_b", 0, 0, 0, 1, 0, 0, 0);

    // Enable gating.
    step("gate_load3", 0, 1, 8'd3, 0, 3, 1, 0);
    step("gate_en1", 0, 0, 0, 1, 2, 1, 0);
    step("gate_en0a", 0, 0, 0, 0, 2, 1, 0);
    step("gate_en0b", 0, 0, 0, 0, 2, 1, 0);
    step("gate_en1b", 0, 0, 0, 1, 1, 1, 0);
    step("gate_done", 0, 0, 0, 1, 0, 0, 1);
    step("gate_after", 0, 0, 0, 1, 0, 0, 0);

    // Full-scale count, no wrap.
    step("ff_load", 0, 1, 8'hFF, 1, 255, 1, 0);
    for (int k = 1; k < 255; k++)
      step("ff_count", 0, 0, 0, 1, 8'(255 - k), 1, 0);
    step("ff_done", 0, 0, 0, 1, 0, 0, 1);
    step("ff_nowrap", 0, 0, 0, 1, 0, 0, 0);

    // Load of zero while running.
    step("z_load4", 0, 1, 8'd4, 1, 4, 1, 0);
    step("z_load0", 0, 1, 8'd0, 1, 0, 0, 0);
    step("z_idle", 0, 0, 0, 1, 0, 0, 0);

    // Load wins over the 1->0 step.
    step("lw_load2", 0, 1, 8'd2, 1, 2, 1, 0);
    step("lw_1", 0, 0, 0, 1, 1, 1, 0);
    step("lw_load7", 0, 1, 8'd7, 1, 7, 1, 0);
    step("lw_6", 0, 0, 0, 1, 6, 1, 0);

    // Reset mid-count.
    step("rm_load10", 0, 1, 8'd10, 1, 10, 1, 0);
    for (int k = 1; k <= 6; k++)
      step("rm_count", 0, 0, 0, 1, 8'(10 - k), 1, 0);
    step("rm_reset", 1, 0, 0, 1, 0, 0, 0);
    step("rm_idle", 0, 0, 0, 1, 0, 0, 0);

    // Reset on the cycle that would have produced done.
    step("rd_load1", 0, 1, 8'd1, 1, 1, 1, 0);
    step("rd_reset", 1, 0, 0, 1, 0, 0, 0);
    step("rd_idle", 0, 0, 0, 1, 0, 0, 0);

    // Reset and load together.
    step("rl_load3", 0, 1, 8'd3, 0, 3, 1, 0);
    step("rl_both", 1, 1, 8'd9, 1, 0, 0, 0);
`endif

    step("tail", 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
